// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid, flush bubble and saturating stall counter
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [STALL_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_n;
  logic in_fire, out_fire, ld_in, ld_skid, ld_sk, clr;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc;
  assign out_valid = state != EMPTY;
  assign in_ready  = state != FULL;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= EMPTY;
    else state <= state_n;
  always_comb begin
    state_n = state;
    ld_in = 1'b0;
    ld_skid = 1'b0;
    ld_sk = 1'b0;
    clr = 1'b0;
    if (flush) begin
      state_n = EMPTY;
      clr = 1'b1;
    end else
      case (state)
        EMPTY: if (in_fire) begin
          state_n = ONE;
          ld_in = 1'b1;
        end
        ONE: begin
          ld_in = in_fire & out_fire;
          ld_sk = in_fire & ~out_fire;
          clr = ~in_fire & out_fire;
          state_n = ld_sk ? FULL : clr ? EMPTY : ONE;
        end
        default: if (out_fire) begin
          state_n = ONE;
          ld_skid = 1'b1;
        end
      endcase
  end
  // out_pc is left alone when the main entry drains or is flushed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_instr <= BUBBLE;
      out_pc <= '0;
      skid_instr <= '0;
      skid_pc <= '0;
      stall_cycles <= '0;
    end else begin
      if (clr) out_instr <= BUBBLE;
      else if (ld_in) {out_instr, out_pc} <= {in_instr, in_pc};
      else if (ld_skid) {out_instr, out_pc} <= {skid_instr, skid_pc};
      if (ld_sk) {skid_instr, skid_pc} <= {in_instr, in_pc};
      if (out_valid && !out_ready && !flush && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed + randomized checks of pipe_stage_skid against a queue-based reference model
module tb_pipe_stage_skid;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc;} ent_t;
  logic clk = 0, rst = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [31:0] out_instr, out_pc, out_instr2, out_pc2;
  logic [15:0] stall16;
  logic [1:0] stall2;
  int passed = 0, total = 0;
  bit chk_en = 0;
  ent_t q[$];
  logic [31:0] last_pc;
  int scnt;
  bit m_in_fire, m_out_fire;
  int exp5[6] = '{1, 2, 3, 3, 3, 3};

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .stall_cycles(stall16)
  );
  pipe_stage_skid #(.STALL_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2), .out_pc(out_pc2),
    .stall_cycles(stall2)
  );

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    else passed++;
  endtask

  // Reference: a FIFO of at most two entries, head is what the stage presents
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      last_pc = 0;
      scnt = 0;
    end else begin
      m_in_fire = in_valid && q.size() < 2;
      m_out_fire = q.size() > 0 && out_ready;
      if (q.size() > 0 && !out_ready && !flush) scnt++;
      if (flush) q.delete();
      else begin
        if (m_out_fire) void'(q.pop_front());
        if (m_in_fire) q.push_back('{in_instr, in_pc});
      end
      if (q.size() > 0) last_pc = q[0].pc;
    end

  always @(posedge clk) begin
    #1;
    if (!rst && chk_en) begin
      chk("m_valid", out_valid, q.size() > 0);
      chk("m_ready", in_ready, q.size() < 2);
      chk("m_instr", out_instr, q.size() > 0 ? q[0].instr : 32'h0);
      chk("m_pc", out_pc, last_pc);
      chk("m_stall16", stall16, scnt > 65535 ? 65535 : scnt);
      chk("m_stall2", stall2, scnt > 3 ? 3 : scnt);
      chk("m_valid2", out_valid2, q.size() > 0);
      chk("m_ready2", in_ready2, q.size() < 2);
      chk("m_instr2", out_instr2, q.size() > 0 ? q[0].instr : 32'h0);
      chk("m_pc2", out_pc2, last_pc);
    end
  end

  task automatic drive(bit iv, logic [31:0] ins, logic [31:0] pc, bit ordy, bit fl);
    @(negedge clk);
    in_valid = iv;
    in_instr = ins;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    in_valid = 1; in_instr = 32'hdeadbeef; in_pc = 32'hcafef00d; out_ready = 1; flush = 1;
    #1 rst = 1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_instr", out_instr, 0);
    chk("rst_stall", stall16, 0);
    drive(0, 0, 0, 0, 0);
    rst = 0;
    chk_en = 1;
    for (int k = 0; k < 4; k++) begin
      drive(1, $urandom, 32'(4 * k), 1, 0);
      tick;
      chk("stream_pc", out_pc, 4 * k);
      chk("stream_valid", out_valid, 1);
      chk("stream_ready", in_ready, 1);
    end
    drive(0, 0, 0, 1, 0); tick;
    chk("drain_valid", out_valid, 0);
    drive(1, 32'hA, 32'h10, 0, 0); tick;
    chk("skid_a_pc", out_pc, 32'h10);
    drive(1, 32'hB, 32'h14, 0, 0); tick;
    chk("skid_full_ready", in_ready, 0);
    chk("skid_full_instr", out_instr, 32'hA);
    drive(0, 0, 0, 0, 0); tick;
    chk("skid_hold_pc", out_pc, 32'h10);
    drive(0, 0, 0, 1, 0); tick;
    chk("skid_b_pc", out_pc, 32'h14);
    chk("skid_b_instr", out_instr, 32'hB);
    chk("skid_b_ready", in_ready, 1);
    drive(0, 0, 0, 1, 0); tick;
    chk("skid_empty", out_valid, 0);
    drive(1, 32'hC, 32'h20, 0, 0); tick;
    drive(1, 32'hD, 32'h24, 0, 0); tick;
    chk("flush_pre_ready", in_ready, 0);
    drive(1, 32'hE, 32'h28, 1, 1); tick;
    chk("flush_valid", out_valid, 0);
    chk("flush_instr", out_instr, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_pc_hold", out_pc, 32'h20);
    drive(0, 0, 0, 1, 0); tick;
    chk("flush_no_capture", out_valid, 0);
    drive(1, 32'hF, 32'h30, 0, 0); tick;
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_pc", out_pc, 0);
    chk("async_stall", stall16, 0);
    drive(0, 0, 0, 0, 0);
    rst = 0;
    drive(1, 32'h11, 32'h40, 0, 0); tick;
    chk("stall_start", stall2, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0); tick;
      chk("stall_sat2", stall2, exp5[i]);
      chk("stall_16", stall16, i + 1);
      chk("stall_hold_instr", out_instr, 32'h11);
    end
    for (int i = 0; i < 10000; i++)
      drive($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
